// File: rtl/lfsr_parity_checker.sv
// Receive-side checker for the x^7+x^6+1 LFSR + parity word stream: parity check,
// self-synchronising LFSR lock FSM and word/error counters. Optional macro: LFSR_CHK_ERR_SAT_EN.
module lfsr_parity_checker #(
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             clr_counts,
   output logic             locked,
   output logic             parity_err,
   output logic             seq_err,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // match counts predicted words after the seed, so lock fires when it reaches LOCK_CNT-1
   localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
   localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

   state_t           state_q, state_d;
   logic [6:0]       exp_q, exp_d;
   logic [3:0]       match_q, match_d;
   logic [3:0]       miss_q, miss_d;
   logic             perr_q, perr_d;
   logic             serr_q, serr_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0] ecnt_q, ecnt_d;
   logic             par_ok, seed_ok, pred_ok, word_err;

   function automatic logic [6:0] lfsr_next(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   always_comb begin
      par_ok   = ^in_data;
      seed_ok  = par_ok && (in_data[6:0] != '0);
      pred_ok  = par_ok && (in_data[6:0] == exp_q);
      word_err = 1'b0;
      state_d  = state_q;
      exp_d    = exp_q;
      match_d  = match_q;
      miss_d   = miss_q;
      perr_d   = 1'b0;
      serr_d   = 1'b0;
      wcnt_d   = wcnt_q;
      ecnt_d   = ecnt_q;

      if (in_valid) begin
         perr_d = ~par_ok;
         unique case (state_q)
            HUNT: begin
               if (seed_ok) begin
                  exp_d   = lfsr_next(in_data[6:0]);
                  match_d = '0;
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               if (pred_ok) begin
                  exp_d = lfsr_next(exp_q);
                  if (match_q == LOCK_LAST) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end else begin
                     match_d = match_q + 4'd1;
                  end
               end else if (seed_ok) begin
                  exp_d   = lfsr_next(in_data[6:0]);
                  match_d = '0;
               end else begin
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               exp_d    = lfsr_next(exp_q);
               serr_d   = (in_data[6:0] != exp_q);
               word_err = ~pred_ok;
               if (word_err) begin
                  if (miss_q == UNLOCK_LAST) state_d = HUNT;
                  else                       miss_d  = miss_q + 4'd1;
               end else begin
                  miss_d = '0;
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (clr_counts) begin
         wcnt_d = '0;
         ecnt_d = '0;
      end else if (in_valid) begin
         wcnt_d = wcnt_q + CNT_W'(1);
         if (word_err) begin
`ifdef LFSR_CHK_ERR_SAT_EN
            if (ecnt_q != '1) ecnt_d = ecnt_q + CNT_W'(1);
`else
            ecnt_d = ecnt_q + CNT_W'(1);
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         exp_q   <= '0;
         match_q <= '0;
         miss_q  <= '0;
         perr_q  <= 1'b0;
         serr_q  <= 1'b0;
         wcnt_q  <= '0;
         ecnt_q  <= '0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         match_q <= match_d;
         miss_q  <= miss_d;
         perr_q  <= perr_d;
         serr_q  <= serr_d;
         wcnt_q  <= wcnt_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign locked     = (state_q == LOCKED);
   assign parity_err = perr_q;
   assign seq_err    = serr_q;
   assign word_count = wcnt_q;
   assign err_count  = ecnt_q;

endmodule

// File: tb/tb_lfsr_parity_checker.sv
// Bench for lfsr_parity_checker: directed scenarios plus randomized traffic, two instances
// (default and CNT_W=4/UNLOCK_CNT=15) checked against a behavioural reference model.
module tb_lfsr_parity_checker;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        clr_counts;

   logic        lk0, pe0, se0;
   logic [15:0] wc0, ec0;
   logic        lk4, pe4, se4;
   logic [3:0]  wc4, ec4;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   lfsr_parity_checker dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_counts(clr_counts),
      .locked(lk0), .parity_err(pe0), .seq_err(se0), .word_count(wc0), .err_count(ec0)
   );

   lfsr_parity_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_counts(clr_counts),
      .locked(lk4), .parity_err(pe4), .seq_err(se4), .word_count(wc4), .err_count(ec4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: mode 0=hunting, 1=verifying, 2=locked
   int lk_n[2]  = '{4, 4};
   int ulk_n[2] = '{3, 15};
   int cw[2]    = '{16, 4};
   int mode[2], pred[2], good[2], bad[2], wcm[2], ecm[2];
   bit e_lock[2], e_perr[2], e_serr[2];

   function automatic int nxt(input int s);
      return ((s << 1) & 127) | (((s >> 6) ^ (s >> 5)) & 1);
   endfunction

   function automatic logic [7:0] mk(input int s);
      logic [6:0] st;
      st = 7'(s);
      return {($countones(st) % 2 == 0) ? 1'b1 : 1'b0, st};
   endfunction

   task automatic model_step(input int m, input bit r, input bit v, input bit c, input logic [7:0] d);
      int s;
      bit pok, seedok, counted;
      s       = int'(d[6:0]);
      pok     = ($countones(d) % 2) == 1;
      seedok  = pok && (s != 0);
      counted = 1'b0;
      e_perr[m] = 1'b0;
      e_serr[m] = 1'b0;
      if (r) begin
         mode[m] = 0; pred[m] = 0; good[m] = 0; bad[m] = 0; wcm[m] = 0; ecm[m] = 0;
         e_lock[m] = 1'b0;
         return;
      end
      if (v) begin
         e_perr[m] = !pok;
         if (mode[m] == 0) begin
            if (seedok) begin pred[m] = nxt(s); good[m] = 0; mode[m] = 1; end
         end else if (mode[m] == 1) begin
            if (pok && s == pred[m]) begin
               good[m]++;
               pred[m] = nxt(pred[m]);
               if (good[m] == lk_n[m]) begin mode[m] = 2; bad[m] = 0; end
            end else if (seedok) begin
               pred[m] = nxt(s); good[m] = 0;
            end else begin
               mode[m] = 0;
            end
         end else begin
            counted   = !pok || (s != pred[m]);
            e_serr[m] = (s != pred[m]);
            pred[m]   = nxt(pred[m]);
            if (counted) begin
               bad[m]++;
               if (bad[m] == ulk_n[m]) mode[m] = 0;
            end else begin
               bad[m] = 0;
            end
         end
      end
      if (c) begin
         wcm[m] = 0; ecm[m] = 0;
      end else if (v) begin
         wcm[m] = (wcm[m] + 1) % (1 << cw[m]);
         if (counted) begin
`ifdef LFSR_CHK_ERR_SAT_EN
            if (ecm[m] < (1 << cw[m]) - 1) ecm[m]++;
`else
            ecm[m] = (ecm[m] + 1) % (1 << cw[m]);
`endif
         end
      end
      e_lock[m] = (mode[m] == 2);
   endtask

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("locked0",  int'(lk0), int'(e_lock[0]));
      check("perr0",    int'(pe0), int'(e_perr[0]));
      check("serr0",    int'(se0), int'(e_serr[0]));
      check("wcount0",  int'(wc0), wcm[0]);
      check("ecount0",  int'(ec0), ecm[0]);
      check("locked4",  int'(lk4), int'(e_lock[1]));
      check("perr4",    int'(pe4), int'(e_perr[1]));
      check("serr4",    int'(se4), int'(e_serr[1]));
      check("wcount4",  int'(wc4), wcm[1]);
      check("ecount4",  int'(ec4), ecm[1]);
   endtask

   task automatic step(input bit r, input bit v, input logic [7:0] d, input bit c);
      rst = r; in_valid = v; in_data = d; clr_counts = c;
      @(posedge clk);
      model_step(0, r, v, c, d);
      model_step(1, r, v, c, d);
      #1;
      compare_all();
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b0, 1'b1, d, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      int g, kind, sat_exp;
      bit r, v, c;
      logic [7:0] d;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_counts = 1'b0;

      // reset state
      do_reset();
      check("rst_locked", int'(lk0), 0);
      check("rst_wc",     int'(wc0), 0);

      // clean lock
      send(8'h01); send(8'h02); send(8'h04); send(8'h08);
      check("lock_early", int'(lk0), 0);
      send(8'h10);
      check("lock_5th", int'(lk0), 1);
      send(8'h20); send(8'hC1);
      check("clean_wc", int'(wc0), 7);
      check("clean_ec", int'(ec0), 0);

      // parity fault while locked
      do_reset();
      send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h10); send(8'h20);
      send(8'h41);
      check("pf_perr", int'(pe0), 1);
      check("pf_serr", int'(se0), 0);
      check("pf_ec",   int'(ec0), 1);
      check("pf_lock", int'(lk0), 1);
      send(8'h83);
      check("pf_next_perr", int'(pe0), 0);

      // sequence slip
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("clr_ec", int'(ec0), 0);
      send(8'h83);
      check("slip1_serr", int'(se0), 1);
      send(8'h83);
      check("slip2_lock", int'(lk0), 1);
      send(8'h83);
      check("slip3_ec",   int'(ec0), 3);
      check("slip3_lock", int'(lk0), 0);

      // seed rejection
      send(8'h80);
      check("seed0_perr", int'(pe0), 0);
      send(8'h81);
      check("seedbad_perr", int'(pe0), 1);

      // clear collision
      send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h10);
      step(1'b0, 1'b1, 8'h83, 1'b1);
      check("coll_serr", int'(se0), 1);
      check("coll_wc",   int'(wc0), 0);
      check("coll_ec",   int'(ec0), 0);

      // err_count saturation / wrap on the 4-bit instance
      do_reset();
      g = 1;
      for (int i = 0; i < 5; i++) begin send(mk(g)); g = nxt(g); end
      for (int i = 0; i < 12; i++) begin send(mk(g) ^ 8'h80); g = nxt(g); end
      send(mk(g)); g = nxt(g);
      for (int i = 0; i < 8; i++) begin send(mk(g) ^ 8'h80); g = nxt(g); end
`ifdef LFSR_CHK_ERR_SAT_EN
      sat_exp = 15;
`else
      sat_exp = 4;
`endif
      check("sat_ec4",   int'(ec4), sat_exp);
      check("sat_lock4", int'(lk4), 1);

      // randomized traffic
      g = 1;
      for (int i = 0; i < 3000; i++) begin
         r    = ($urandom_range(0, 199) == 0);
         v    = ($urandom_range(0, 9) < 8);
         c    = ($urandom_range(0, 49) == 0);
         kind = int'($urandom_range(0, 19));
         if (kind < 16)      d = mk(g);
         else if (kind < 18) d = mk(g) ^ 8'h80;
         else                d = 8'($urandom_range(0, 255));
         if (v && kind < 18) g = nxt(g);
         if (r) g = int'($urandom_range(1, 127));
         step(r, v, d, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
